// File: rtl/sample_clip_win.sv
// Windowed grid sub-sampler with show-ahead sample FIFO.
// Define SAMPLE_CLIP_AVG_EN to average each hit with its right-hand partner.
module sample_clip_win #(
   parameter int PIX_W = 10,
   parameter int CH    = 3,
   parameter int COL_W = 10,
   parameter int ROW_W = 10,
   parameter int WIN_W = 32,
   parameter int WIN_H = 32,
   parameter int STEP  = 4,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_start,
   input  logic [COL_W-1:0]           x0,
   input  logic [ROW_W-1:0]           y0,
   input  logic                       ipix_valid,
   input  logic [CH*PIX_W-1:0]        ipixel,
   input  logic [COL_W-1:0]           icol,
   input  logic [ROW_W-1:0]           irow,
   input  logic                       rd_req,
   output logic                       o_valid,
   output logic [CH*PIX_W-1:0]        opixel,
   output logic [$clog2(WIN_W)-1:0]   o_scol,
   output logic [$clog2(WIN_H)-1:0]   o_srow,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       frame_done,
   output logic                       overflow
);
   localparam int DW  = CH*PIX_W;
   localparam int SCW = $clog2(WIN_W);
   localparam int SRW = $clog2(WIN_H);
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = $clog2(DEPTH+1);
   localparam int EW  = SRW+SCW+DW;
   localparam logic [COL_W:0] CSTEP = (COL_W+1)'(STEP);
   localparam logic [ROW_W:0] RSTEP = (ROW_W+1)'(STEP);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t         state;
   logic [COL_W:0] x0_q;
   logic [COL_W:0] tgt_col;
   logic [ROW_W:0] tgt_row;
   logic [SCW-1:0] scol;
   logic [SRW-1:0] srow;
   logic [EW-1:0]  mem [DEPTH];
   logic [EW-1:0]  head;
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [LW-1:0]  cnt;

   logic          hit;
   logic          last_col;
   logic          last_hit;
   logic          pop;
   logic          full;
   logic          push_req;
   logic          push;
   logic          done_now;
   logic [EW-1:0] push_data;

   assign hit = (state == CAPTURE) && ipix_valid && !frame_start &&
                ({1'b0, icol} == tgt_col) &&
                ({1'b0, irow} == tgt_row);
   assign last_col = (scol == SCW'(WIN_W-1));
   assign last_hit = last_col && (srow == SRW'(WIN_H-1));

`ifdef SAMPLE_CLIP_AVG_EN
   logic                 hold_vld;
   logic                 hold_last;
   logic [DW-1:0]        hold_pix;
   logic [SRW+SCW-1:0]   hold_pos;
   logic [ROW_W-1:0]     hold_row;
   logic                 partner;
   logic [DW-1:0]        avg_pix;

   assign partner = hold_vld && ipix_valid && !frame_start;

   for (genvar c = 0; c < CH; c++) begin : g_avg
      logic [PIX_W:0] sum;
      assign sum = {1'b0, hold_pix[c*PIX_W +: PIX_W]} +
                   {1'b0, ipixel[c*PIX_W +: PIX_W]};
      assign avg_pix[c*PIX_W +: PIX_W] = sum[PIX_W:1];
   end

   assign push_req  = partner;
   assign done_now  = partner && hold_last;
   assign push_data = {hold_pos,
                       (irow == hold_row) ? avg_pix : hold_pix};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_vld  <= 1'b0;
         hold_last <= 1'b0;
         hold_pix  <= '0;
         hold_pos  <= '0;
         hold_row  <= '0;
      end else if (frame_start) begin
         hold_vld  <= 1'b0;
         hold_last <= 1'b0;
      end else if (hit) begin
         hold_vld  <= 1'b1;
         hold_last <= last_hit;
         hold_pix  <= ipixel;
         hold_pos  <= {srow, scol};
         hold_row  <= irow;
      end else if (partner) begin
         hold_vld  <= 1'b0;
      end
   end
`else
   assign push_req  = hit;
   assign done_now  = hit && last_hit;
   assign push_data = {srow, scol, ipixel};
`endif

   assign full = (cnt == LW'(DEPTH));
   assign pop  = rd_req && o_valid && !frame_start;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign push = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         x0_q       <= '0;
         tgt_col    <= '0;
         tgt_row    <= '0;
         scol       <= '0;
         srow       <= '0;
         wptr       <= '0;
         rptr       <= '0;
         cnt        <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_start) begin
            state    <= CAPTURE;
            x0_q     <= {1'b0, x0};
            tgt_col  <= {1'b0, x0};
            tgt_row  <= {1'b0, y0};
            scol     <= '0;
            srow     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
         end else begin
            if (hit) begin
               if (last_col) begin
                  scol    <= '0;
                  tgt_col <= x0_q;
                  srow    <= srow + 1'b1;
                  tgt_row <= tgt_row + RSTEP;
                  if (last_hit) state <= DONE;
               end else begin
                  scol    <= scol + 1'b1;
                  tgt_col <= tgt_col + CSTEP;
               end
            end
            if (done_now) frame_done <= 1'b1;
            if (push_req && !push) overflow <= 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
         end
      end
   end

   assign head    = mem[rptr];
   assign o_valid = (cnt != '0);
   assign opixel  = o_valid ? head[DW-1:0] : '0;
   assign o_scol  = o_valid ? head[DW +: SCW] : '0;
   assign o_srow  = o_valid ? head[DW+SCW +: SRW] : '0;
   assign level   = cnt;

endmodule

// File: tb/tb_sample_clip_win.sv
// Directed bench for sample_clip_win (4x4 grid, stride 2, 8-deep FIFO).
// Averaged expectations apply when SAMPLE_CLIP_AVG_EN is defined.
module tb_sample_clip_win;
   localparam int PW = 10;
   localparam int NC = 3;
   localparam int CW = 10;
   localparam int RW = 10;
   localparam int WW = 4;
   localparam int WH = 4;
   localparam int ST = 2;
   localparam int DP = 8;
`ifdef SAMPLE_CLIP_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_start;
   logic [CW-1:0] x0;
   logic [RW-1:0] y0;
   logic          ipix_valid;
   logic [29:0]   ipixel;
   logic [CW-1:0] icol;
   logic [RW-1:0] irow;
   logic          rd_req;
   logic          o_valid;
   logic [29:0]   opixel;
   logic [1:0]    o_scol;
   logic [1:0]    o_srow;
   logic [3:0]    level;
   logic          frame_done;
   logic          overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   logic [33:0] q[$];

   always #5 clk = ~clk;

   sample_clip_win #(
      .PIX_W(PW), .CH(NC), .COL_W(CW), .ROW_W(RW),
      .WIN_W(WW), .WIN_H(WH), .STEP(ST), .DEPTH(DP)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .x0(x0), .y0(y0), .ipix_valid(ipix_valid),
      .ipixel(ipixel), .icol(icol), .irow(irow),
      .rd_req(rd_req), .o_valid(o_valid), .opixel(opixel),
      .o_scol(o_scol), .o_srow(o_srow), .level(level),
      .frame_done(frame_done), .overflow(overflow)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] pix(int c, int r);
      return {10'(c ^ r), 10'(r), 10'(c)};
   endfunction

   function automatic logic [29:0] exp_pix(int c, int r);
      logic [29:0] p;
      logic [29:0] n;
      logic [29:0] o;
      logic [10:0] s;
      p = pix(c, r);
      n = pix(c + 1, r);
      o = p;
      if (AVG) begin
         for (int k = 0; k < 3; k++) begin
            s = {1'b0, p[k*10 +: 10]} + {1'b0, n[k*10 +: 10]};
            o[k*10 +: 10] = s[10:1];
         end
      end
      return o;
   endfunction

   function automatic logic [33:0] ent(int i);
      int sr;
      int sc;
      sr = i / WW;
      sc = i % WW;
      return {2'(sr), 2'(sc), exp_pix(3 + ST*sc, 1 + ST*sr)};
   endfunction

   task automatic step();
      if (rd_req && o_valid) q.push_back({o_srow, o_scol, opixel});
      @(posedge clk);
      #1;
      if (frame_done) n_done++;
   endtask

   task automatic send(input int c, input int r, input logic [29:0] p);
      ipix_valid = 1'b1;
      icol = CW'(c);
      irow = RW'(r);
      ipixel = p;
      step();
      ipix_valid = 1'b0;
   endtask

   task automatic start(input int x, input int y);
      frame_start = 1'b1;
      x0 = CW'(x);
      y0 = RW'(y);
      step();
      frame_start = 1'b0;
      n_done = 0;
   endtask

   task automatic raster();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 16; c++)
            send(c, r, pix(c, r));
      step();
   endtask

   task automatic drain(input string tag, input int n);
      q.delete();
      rd_req = 1'b1;
      for (int k = 0; k < 20; k++) step();
      rd_req = 1'b0;
      chk(tag, 64'(q.size()), 64'(n));
   endtask

   task automatic pair(input int i);
      send(3 + ST*(i % WW), 1 + ST*(i / WW),
           pix(3 + ST*(i % WW), 1 + ST*(i / WW)));
      send(4 + ST*(i % WW), 1 + ST*(i / WW),
           pix(4 + ST*(i % WW), 1 + ST*(i / WW)));
   endtask

   initial begin
      reset = 1'b1;
      frame_start = 1'b0;
      x0 = '0;
      y0 = '0;
      ipix_valid = 1'b0;
      ipixel = '0;
      icol = '0;
      irow = '0;
      rd_req = 1'b0;
      step();
      step();
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_opix", 64'(opixel), 64'd0);
      reset = 1'b0;
      step();

      // streaming frame, consumer always ready
      start(3, 1);
      q.delete();
      rd_req = 1'b1;
      raster();
      for (int k = 0; k < 6; k++) step();
      rd_req = 1'b0;
      chk("f1_cnt", 64'(q.size()), 64'd16);
      for (int i = 0; i < 16 && i < q.size(); i++)
         chk($sformatf("f1_ent%0d", i), 64'(q[i]), 64'(ent(i)));
      chk("f1_done", 64'(n_done), 64'd1);
      chk("f1_ovf", 64'(overflow), 64'd0);

      // same frame, consumer stalled
      start(3, 1);
      raster();
      chk("f2_level", 64'(level), 64'd8);
      chk("f2_ovf", 64'(overflow), 64'd1);
      chk("f2_done", 64'(n_done), 64'd1);
      drain("f2_cnt", 8);
      for (int i = 0; i < 8 && i < q.size(); i++)
         chk($sformatf("f2_ent%0d", i), 64'(q[i]), 64'(ent(i)));

      // full FIFO with a pop on the write cycle
      start(3, 1);
      for (int i = 0; i < 8; i++) pair(i);
      chk("f3_full", 64'(level), 64'd8);
      rd_req = !AVG;
      send(3, 5, pix(3, 5));
      rd_req = AVG;
      send(4, 5, pix(4, 5));
      rd_req = 1'b0;
      chk("f3_level", 64'(level), 64'd8);
      chk("f3_ovf", 64'(overflow), 64'd0);
      drain("f3_cnt", 8);
      for (int i = 0; i < 8 && i < q.size(); i++)
         chk($sformatf("f3_ent%0d", i), 64'(q[i]), 64'(ent(i + 1)));

      rd_req = 1'b1;
      step();
      step();
      rd_req = 1'b0;
      chk("empty_rd_level", 64'(level), 64'd0);
      chk("empty_rd_valid", 64'(o_valid), 64'd0);

      // targets run past the sensor edge
      start(1022, 1);
      for (int c = 1018; c < 1024; c++) send(c, 1, pix(c, 1));
      send(0, 2, pix(0, 2));
      step();
      chk("edge_level", 64'(level), 64'd1);
      chk("edge_opix", 64'(opixel), 64'(exp_pix(1022, 1)));
      chk("edge_done", 64'(n_done), 64'd0);
      start(3, 1);
      chk("recover_flush", 64'(level), 64'd0);
      pair(0);
      chk("recover_level", 64'(level), 64'd1);
      chk("recover_opix", 64'(opixel), 64'(exp_pix(3, 1)));

`ifdef SAMPLE_CLIP_AVG_EN
      start(3, 1);
      send(3, 1, {20'd0, 10'd100});
      send(4, 1, {20'd0, 10'd201});
      chk("avg_ch0", 64'(opixel[9:0]), 64'd150);
      start(15, 1);
      send(15, 1, {10'd7, 10'd8, 10'd9});
      send(0, 2, {10'd500, 10'd500, 10'd500});
      chk("avg_eol_level", 64'(level), 64'd1);
      chk("avg_eol_pix", 64'(opixel), 64'({10'd7, 10'd8, 10'd9}));
`endif

      // reset while entries are queued
      start(3, 1);
      for (int i = 0; i < 5; i++) pair(i);
      chk("mid_level", 64'(level), 64'd5);
      reset = 1'b1;
      step();
      chk("mid_valid", 64'(o_valid), 64'd0);
      chk("mid_opix", 64'(opixel), 64'd0);
      chk("mid_scol", 64'(o_scol), 64'd0);
      chk("mid_srow", 64'(o_srow), 64'd0);
      chk("mid_lvl0", 64'(level), 64'd0);
      chk("mid_done", 64'(frame_done), 64'd0);
      chk("mid_ovf", 64'(overflow), 64'd0);
      reset = 1'b0;
      pair(0);
      step();
      chk("idle_nowrite", 64'(level), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
